read_batch_fetch: RTL and testbench

- Upstream feeder of the read-RAM stage: fetches one batch of reads from host memory, cache line by cache line.
- Line 0 of a batch is a header carrying the batch size. The header is followed by 4 lines per read, in this order: read part 1, read part 2, param, ik.
- Forwards every data line in request order as a load_valid/load_data stream and presents a stable batch_size for the read-RAM stage's load_done logic.
- Throttles memory requests with an outstanding-request credit counter.

---
 rtl/read_batch_fetch_pkg.sv | 29 ++
 rtl/read_batch_fetch_credit.sv | 37 +++
 rtl/read_batch_fetch.sv | 125 ++++++++++++
 tb/tb_read_batch_fetch.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_batch_fetch_pkg.sv
// Shared constants, header layout and FSM encoding for the batch fetcher.
package read_batch_fetch_pkg;

  localparam int CL             = 512;
  localparam int READ_NUM_WIDTH = 8;
  localparam int MAX_READ       = 256;
  localparam int LINES_PER_READ = 4;
  localparam int LINE_CNT_W     = READ_NUM_WIDTH + 3;

  localparam int HDR_SIZE_LSB = 0;
  localparam int HDR_SIZE_MSB = READ_NUM_WIDTH;

  localparam logic [READ_NUM_WIDTH:0] MAX_SIZE =
    (READ_NUM_WIDTH+1)'(MAX_READ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_HDR_WAIT,
    S_DATA
  } state_e;

  function automatic logic [LINE_CNT_W-1:0] lines_of(
    input logic [READ_NUM_WIDTH:0] n
  );
    return LINE_CNT_W'(n) * LINE_CNT_W'(LINES_PER_READ);
  endfunction

endpackage

// File: rtl/read_batch_fetch_credit.sv
// Outstanding-request credit counter; saturates at both ends.
module fetch_credit_counter #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o
);

  localparam int W = $clog2(MAX) + 1;
  localparam logic [W-1:0] FULL = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         up, dn;

  assign up     = inc_i && (cnt_q != FULL);
  assign dn     = dec_i && (cnt_q != '0);
  assign full_o = (cnt_q == FULL);

  always_comb begin
    cnt_d = cnt_q;
    if (up && !dn)
      cnt_d = cnt_q + W'(1);
    else if (dn && !up)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/read_batch_fetch.sv
// Fetches a header line then 4 lines per read, forwarding data lines in order.
module read_batch_fetch
  import read_batch_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH      = 42,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [ADDR_WIDTH-1:0]     rd_req_addr,
  input  logic                      rd_rsp_valid,
  input  logic [CL-1:0]             rd_rsp_data,
  output logic                      load_valid,
  output logic [CL-1:0]             load_data,
  output logic [READ_NUM_WIDTH:0]   batch_size,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [LINE_CNT_W-1:0]   req_cnt_q, rsp_cnt_q, total_q;
  logic [READ_NUM_WIDTH:0] bsize_q;
  logic                    lv_q, done_q, err_q;
  logic [CL-1:0]           ld_q;

  logic                    hs, full, hdr_bad;
  logic [READ_NUM_WIDTH:0] hdr_size;

  assign hdr_size = rd_rsp_data[HDR_SIZE_MSB:HDR_SIZE_LSB];
  assign hdr_bad  = (hdr_size == '0) || (hdr_size > MAX_SIZE);

  assign rd_req_valid = (state_q == S_HDR) ||
                        ((state_q == S_DATA) &&
                         (req_cnt_q < total_q) && !full);

  // Data lines sit directly after the header line.
  assign rd_req_addr = (state_q == S_DATA)
    ? base_q + ADDR_WIDTH'(req_cnt_q) + ADDR_WIDTH'(1)
    : base_q;

  assign hs = rd_req_valid && rd_req_ready;

  fetch_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (hs),
    .dec_i  (rd_rsp_valid),
    .full_o (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      req_cnt_q <= '0;
      rsp_cnt_q <= '0;
      total_q   <= '0;
      bsize_q   <= '0;
      lv_q      <= 1'b0;
      ld_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      lv_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            state_q   <= S_HDR;
          end
        end
        S_HDR: begin
          if (hs)
            state_q <= S_HDR_WAIT;
        end
        S_HDR_WAIT: begin
          if (rd_rsp_valid) begin
            bsize_q <= hdr_size;
            total_q <= lines_of(hdr_size);
            if (hdr_bad) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (hs)
            req_cnt_q <= req_cnt_q + LINE_CNT_W'(1);
          if (rd_rsp_valid) begin
            lv_q      <= 1'b1;
            ld_q      <= rd_rsp_data;
            rsp_cnt_q <= rsp_cnt_q + LINE_CNT_W'(1);
            if (rsp_cnt_q + LINE_CNT_W'(1) == total_q) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign load_valid = lv_q;
  assign load_data  = ld_q;
  assign batch_size = bsize_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_read_batch_fetch.sv
// Scoreboard bench: in-order memory responder plus a load_valid monitor.
module tb_read_batch_fetch;
  import read_batch_fetch_pkg::*;

  localparam int AW = 42;
  localparam int MO = 16;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] base_addr;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_rsp_valid;
  logic [CL-1:0] rd_rsp_data;
  logic          load_valid;
  logic [CL-1:0] load_data;
  logic [READ_NUM_WIDTH:0] batch_size;
  logic          busy, done, error;

  read_batch_fetch #(.ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .batch_size   (batch_size),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            cyc = 0;
  int            rsp_delay = 2;
  bit            ready_tog = 1'b0;
  bit            hold = 1'b0;
  bit            credit_chk = 1'b0;
  logic [AW-1:0] hdr_addr = '0;
  logic [8:0]    hdr_val = '0;
  logic [AW-1:0] exp_addr = '0;
  int            hs_cnt = 0;
  int            max_out = 0;
  int            lv_cnt = 0;
  int            exp_total = 0;
  logic [AW-1:0] pend_a[$];
  int            pend_due[$];
  logic [CL-1:0] exp_q[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [CL-1:0] pat(input logic [AW-1:0] a);
    logic [CL-1:0] r;
    for (int i = 0; i < CL/32; i++)
      r[i*32 +: 32] = a[31:0] ^ (32'h9E370000 + 32'(i));
    return r;
  endfunction

  function automatic logic [CL-1:0] mem_line(input logic [AW-1:0] a);
    logic [CL-1:0] r;
    if (a == hdr_addr) begin
      r = '0;
      r[8:0] = hdr_val;
      r[CL-1 -: 32] = 32'hFEEDF00D;
    end else begin
      r = pat(a);
    end
    return r;
  endfunction

  // Memory responder: in-order responses, optional hold and ready toggling.
  initial begin
    rd_req_ready = 1'b0;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_a.size() >= MO)
        chk("credit_limit", 64'(rd_req_valid), 64'd0);
      if (credit_chk)
        chk("credits", 64'(dut.u_credit.cnt_q), 64'(pend_a.size()));
      rd_req_ready = ready_tog ? ((cyc % 2) == 0) : 1'b1;
      rd_rsp_valid = 1'b0;
      if (pend_a.size() > 0 && pend_due[0] <= cyc &&
          (!hold || pend_a[0] == hdr_addr)) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = mem_line(pend_a[0]);
        void'(pend_a.pop_front());
        void'(pend_due.pop_front());
      end
      if (rd_req_valid && rd_req_ready && !reset) begin
        chk("req_addr", 64'(rd_req_addr), 64'(exp_addr));
        exp_addr++;
        hs_cnt++;
        if (rd_req_addr != hdr_addr)
          exp_q.push_back(pat(rd_req_addr));
        pend_a.push_back(rd_req_addr);
        pend_due.push_back(cyc + rsp_delay);
        if (pend_a.size() > max_out)
          max_out = pend_a.size();
      end
    end
  end

  // Monitor: every load_valid must match the next expected data line.
  initial begin
    logic [CL-1:0] e;
    forever begin
      @(negedge clk);
      if (load_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL load_unexpected actual=%0h required=none",
                   load_data[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (load_data !== e) begin
            errors++;
            $display("FAIL load_data actual=%0h required=%0h",
                     load_data[31:0], e[31:0]);
          end
          lv_cnt++;
          chk("done_at_load", 64'(done), 64'(lv_cnt == exp_total));
        end
      end
    end
  end

  task automatic start_batch(input logic [AW-1:0] b, input logic [8:0] hv);
    hdr_addr  = b;
    hdr_val   = hv;
    exp_addr  = b;
    hs_cnt    = 0;
    lv_cnt    = 0;
    max_out   = 0;
    exp_total = (hv == 0 || hv > 9'd256) ? 0 : 4 * int'(hv);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start     = 1'b0;
    base_addr = '1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(n < 4000), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic end_checks(input logic [8:0] hv);
    bit ok = (hv != 0) && (hv <= 9'd256);
    chk("done",   64'(done),       64'(ok));
    chk("error",  64'(error),      64'(!ok));
    chk("busy",   64'(busy),       64'd0);
    chk("bsize",  64'(batch_size), 64'(hv));
    chk("lines",  64'(lv_cnt),     64'(ok ? 4 * int'(hv) : 0));
    chk("reqs",   64'(hs_cnt),     64'(ok ? 4 * int'(hv) + 1 : 1));
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_req_addr",  64'(rd_req_addr),  64'd0);
    chk("rst_load_valid", 64'(load_valid),  64'd0);
    chk("rst_load_data", 64'(load_data[63:0]), 64'd0);
    chk("rst_bsize", 64'(batch_size), 64'd0);
    chk("rst_flags", 64'({busy, done, error}), 64'd0);
    reset = 1'b0;

    // Basic batch of three reads
    rsp_delay = 2;
    start_batch(42'h100, 9'd3);
    wait_idle();
    end_checks(9'd3);

    // Credit stall: data responses withheld until 16 are in flight
    hold = 1'b1;
    start_batch(42'h2000, 9'd64);
    n = 0;
    while (hs_cnt < 17 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    chk("stall_valid", 64'(rd_req_valid), 64'd0);
    chk("stall_reqs",  64'(hs_cnt),       64'd17);
    chk("max_out",     64'(max_out),      64'd16);
    hold = 1'b0;
    wait_idle();
    end_checks(9'd64);
    chk("max_out_end", 64'(max_out), 64'd16);

    // Illegal header sizes, then recovery
    start_batch(42'h3000, 9'd0);
    wait_idle();
    end_checks(9'd0);
    start_batch(42'h3100, 9'd257);
    wait_idle();
    end_checks(9'd257);
    start_batch(42'h3200, 9'd2);
    wait_idle();
    end_checks(9'd2);

    // Ready toggling with coincident handshake and response
    ready_tog  = 1'b1;
    credit_chk = 1'b1;
    start_batch(42'h4000, 9'd5);
    wait_idle();
    end_checks(9'd5);
    ready_tog  = 1'b0;
    credit_chk = 1'b0;

    // Reset mid-batch, late responses must be dropped
    rsp_delay = 3;
    start_batch(42'h5000, 9'd2);
    n = 0;
    while (lv_cnt < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_partial", 64'(lv_cnt < 8), 64'd1);
    chk("mid_rst_valid", 64'(rd_req_valid), 64'd0);
    chk("mid_rst_load",  64'(load_valid),   64'd0);
    chk("mid_rst_data",  64'(load_data[63:0]), 64'd0);
    chk("mid_rst_flags", 64'({busy, done, error}), 64'd0);
    chk("mid_rst_bsize", 64'(batch_size), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (pend_a.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("late_rsp_idle", 64'({busy, load_valid}), 64'd0);
    start_batch(42'h5100, 9'd2);
    wait_idle();
    end_checks(9'd2);

    // start while busy must not re-latch the base address
    rsp_delay = 2;
    start_batch(42'h6000, 9'd3);
    repeat (6) @(negedge clk);
    start     = 1'b1;
    base_addr = 42'h7777;
    @(negedge clk);
    start     = 1'b0;
    base_addr = '1;
    wait_idle();
    end_checks(9'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
